// File: rtl/elastic_operator_if.sv
`default_nettype none
// ============================================================================
// Module   : elastic_operator_if
// Brief    : Operand/result handshake bundle of the elastic operator node.
// Revision : 1.0 - initial release
// ============================================================================
interface elastic_operator_if #(
    parameter int data_width  = 32,
    parameter int input_size  = 2,
    parameter int output_size = 1,
    parameter int depth       = 4
);
    localparam int c_occ_w = $clog2(depth) + 1;

    logic [input_size-1:0]            req_l;
    logic [input_size-1:0]            ack_l;
    logic [data_width*input_size-1:0] din;
    logic [output_size-1:0]           req_r;
    logic [output_size-1:0]           ack_r;
    logic [data_width-1:0]            dout;
    logic [c_occ_w-1:0]               occupancy;
    logic [31:0]                      count;

    // master: producers/consumers around the node; slave: the node itself
    modport master (
        input  req_l, ack_r, dout, occupancy, count,
        output ack_l, din, req_r
    );
    modport slave (
        output req_l, ack_r, dout, occupancy, count,
        input  ack_l, din, req_r
    );
endinterface
`default_nettype wire

// File: rtl/elastic_operator.sv
`default_nettype none
// ============================================================================
// Module   : elastic_operator
// Brief    : N-operand arithmetic node with result FIFO and M-way fan-out.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_operator #(
    parameter int    data_width  = 32,
    parameter string op          = "add",
    parameter int    immediate   = 0,
    parameter int    input_size  = 2,
    parameter int    output_size = 1,
    parameter int    depth       = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    elastic_operator_if.slave bus
);
    localparam int c_aw = $clog2(depth);
    localparam int c_ow = c_aw + 1;
    localparam logic [c_ow-1:0] c_depth = c_ow'(depth);

    localparam logic [3:0] c_op_reg  = 4'd0;
    localparam logic [3:0] c_op_addi = 4'd1;
    localparam logic [3:0] c_op_subi = 4'd2;
    localparam logic [3:0] c_op_muli = 4'd3;
    localparam logic [3:0] c_op_add  = 4'd4;
    localparam logic [3:0] c_op_sub  = 4'd5;
    localparam logic [3:0] c_op_mul  = 4'd6;
    // "in", "out" and unknown names all fall through to the pass-lane0 case
    localparam logic [3:0] c_op_sel =
        (op == "addi") ? c_op_addi :
        (op == "subi") ? c_op_subi :
        (op == "muli") ? c_op_muli :
        (op == "add")  ? c_op_add  :
        (op == "sub")  ? c_op_sub  :
        (op == "mul")  ? c_op_mul  : c_op_reg;

    logic [input_size-1:0]  req_l_q, req_l_d, has_q, has_d;
    logic [data_width-1:0]  opnd_q [input_size];
    logic [data_width-1:0]  opnd_d [input_size];
    logic [c_aw-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [c_ow-1:0]        occ_q, occ_d;
    logic [31:0]            count_q, count_d;
    logic [output_size-1:0] served_q, served_d, ack_r_q, ack_r_d;
    logic [data_width-1:0]  mem_q [depth];

    logic                   w_nonempty, w_push, w_pop;
    logic [output_size-1:0] w_fire;
    logic [data_width-1:0]  w_result;
    logic [data_width-1:0]  w_imm;

    assign w_imm      = data_width'(immediate);
    assign w_nonempty = (occ_q != '0);
    // push decision uses registered occupancy only, no same-cycle pop bypass
    assign w_push     = (&has_q) && (occ_q < c_depth);
    assign w_fire     = {output_size{w_nonempty}} & bus.req_r & ~served_q & ~ack_r_q;
    assign w_pop      = w_nonempty && (&served_q);

    always_comb begin
        req_l_d = req_l_q;
        has_d   = has_q;
        opnd_d  = opnd_q;
        for (int i = 0; i < input_size; i++) begin
            if (bus.ack_l[i] && req_l_q[i]) begin
                has_d[i]   = 1'b1;
                req_l_d[i] = 1'b0;
                opnd_d[i]  = bus.din[data_width*i +: data_width];
            end else if (!has_q[i] && !req_l_q[i]) begin
                req_l_d[i] = 1'b1;
            end
        end
        if (w_push) begin
            has_d = '0;
        end
    end

    always_comb begin
        w_result = opnd_q[0];
        case (c_op_sel)
            c_op_addi: w_result = opnd_q[0] + w_imm;
            c_op_subi: w_result = opnd_q[0] - w_imm;
            c_op_muli: w_result = opnd_q[0] * w_imm;
            c_op_add: begin
                for (int i = 1; i < input_size; i++) w_result = w_result + opnd_q[i];
            end
            c_op_sub: begin
                for (int i = 1; i < input_size; i++) w_result = w_result - opnd_q[i];
            end
            c_op_mul: begin
                for (int i = 1; i < input_size; i++) w_result = w_result * opnd_q[i];
            end
            default: w_result = opnd_q[0];
        endcase
    end

    always_comb begin
        wptr_d   = w_push ? wptr_q + c_aw'(1) : wptr_q;
        rptr_d   = w_pop  ? rptr_q + c_aw'(1) : rptr_q;
        count_d  = w_push ? count_q + 32'd1 : count_q;
        ack_r_d  = w_fire;
        served_d = w_pop ? '0 : (served_q | w_fire);
        occ_d    = occ_q;
        if (w_push && !w_pop) begin
            occ_d = occ_q + c_ow'(1);
        end else if (!w_push && w_pop) begin
            occ_d = occ_q - c_ow'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q  <= '0;
            has_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            count_q  <= '0;
            served_q <= '0;
            ack_r_q  <= '0;
        end else begin
            req_l_q  <= req_l_d;
            has_q    <= has_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
            served_q <= served_d;
            ack_r_q  <= ack_r_d;
        end
    end

    // Operand latches and FIFO storage carry no reset; has/occupancy qualify them
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        if (w_push) begin
            mem_q[wptr_q] <= w_result;
        end
    end

    assign bus.req_l     = req_l_q;
    assign bus.ack_r     = ack_r_q;
    assign bus.dout      = w_nonempty ? mem_q[rptr_q] : '0;
    assign bus.occupancy = occ_q;
    assign bus.count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_elastic_operator.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_operator
// Brief    : Directed self-checking bench over add/sub/muli/fan-out variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_operator;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   ack0_cnt = 0;
    int   ack1_cnt = 0;

    elastic_operator_if #(.data_width(32), .input_size(2), .output_size(1), .depth(4)) if_add ();
    elastic_operator_if #(.data_width(32), .input_size(3), .output_size(1), .depth(4)) if_sub ();
    elastic_operator_if #(.data_width(32), .input_size(1), .output_size(1), .depth(4)) if_mul ();
    elastic_operator_if #(.data_width(32), .input_size(1), .output_size(2), .depth(4)) if_fan ();

    elastic_operator #(.data_width(32), .op("add"), .immediate(0), .input_size(2),
                       .output_size(1), .depth(4)) u_add (.clk(clk), .rst(rst), .bus(if_add));
    elastic_operator #(.data_width(32), .op("sub"), .immediate(0), .input_size(3),
                       .output_size(1), .depth(4)) u_sub (.clk(clk), .rst(rst), .bus(if_sub));
    elastic_operator #(.data_width(32), .op("muli"), .immediate(3), .input_size(1),
                       .output_size(1), .depth(4)) u_mul (.clk(clk), .rst(rst), .bus(if_mul));
    elastic_operator #(.data_width(32), .op("reg"), .immediate(0), .input_size(1),
                       .output_size(2), .depth(4)) u_fan (.clk(clk), .rst(rst), .bus(if_fan));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_fan.ack_r[0] === 1'b1) ack0_cnt++;
        if (if_fan.ack_r[1] === 1'b1) ack1_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // 0=add 1=sub 2=muli 3=fan
    function automatic logic get_req_l(input int inst, input int idx);
        case (inst)
            0:       return if_add.req_l[idx];
            1:       return if_sub.req_l[idx];
            2:       return if_mul.req_l[0];
            default: return if_fan.req_l[0];
        endcase
    endfunction

    function automatic logic [1:0] get_ack(input int inst);
        case (inst)
            0:       return {1'b0, if_add.ack_r};
            1:       return {1'b0, if_sub.ack_r};
            2:       return {1'b0, if_mul.ack_r};
            default: return if_fan.ack_r;
        endcase
    endfunction

    function automatic logic [31:0] get_dout(input int inst);
        case (inst)
            0:       return if_add.dout;
            1:       return if_sub.dout;
            2:       return if_mul.dout;
            default: return if_fan.dout;
        endcase
    endfunction

    task automatic set_lane(input int inst, input int idx, input logic [31:0] val, input logic a);
        case (inst)
            0: begin if_add.din[32*idx +: 32] = val; if_add.ack_l[idx] = a; end
            1: begin if_sub.din[32*idx +: 32] = val; if_sub.ack_l[idx] = a; end
            2: begin if_mul.din = val; if_mul.ack_l[0] = a; end
            default: begin if_fan.din = val; if_fan.ack_l[0] = a; end
        endcase
    endtask

    // Waits for the lane request, then acks it for exactly one edge
    task automatic send(input int inst, input int idx, input logic [31:0] val);
        int n;
        n = 0;
        while (get_req_l(inst, idx) !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL send_timeout inst=%0d lane=%0d got=no_req exp=req", inst, idx);
        end else begin
            set_lane(inst, idx, val, 1'b1);
            @(posedge clk); #1;
            set_lane(inst, idx, val, 1'b0);
        end
    endtask

    task automatic wait_ack(input int inst, input int b, output bit ok);
        logic [1:0] a;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(posedge clk); #1;
            a = get_ack(inst);
            if (a[b] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        if_add.ack_l = '0; if_sub.ack_l = '0; if_mul.ack_l = '0; if_fan.ack_l = '0;
        if_add.req_r = '0; if_sub.req_r = '0; if_mul.req_r = '0; if_fan.req_r = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (if_add.req_l !== 2'b00) begin bad++; $display("FAIL rst_req_l got=%b exp=00", if_add.req_l); end
        total++; if (if_add.ack_r !== 1'b0) begin bad++; $display("FAIL rst_ack_r got=%b exp=0", if_add.ack_r); end
        total++; if (if_add.occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", if_add.occupancy); end
        total++; if (if_add.count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", if_add.count); end
        total++; if (if_add.dout !== 32'd0) begin bad++; $display("FAIL rst_dout got=%0h exp=0", if_add.dout); end
        total++; if (if_fan.ack_r !== 2'b00) begin bad++; $display("FAIL rst_fan_ack got=%b exp=00", if_fan.ack_r); end
    endtask

    task automatic test_add();
        do_reset();
        if_add.req_r = 1'b1;
        send(0, 0, 32'd3);
        send(0, 1, 32'd5);
        @(posedge clk); #1;
        total++; if (if_add.ack_r !== 1'b0) begin bad++; $display("FAIL add_ack_early got=%b exp=0", if_add.ack_r); end
        total++; if (if_add.occupancy !== 3'd1) begin bad++; $display("FAIL add_occ1 got=%0d exp=1", if_add.occupancy); end
        total++; if (if_add.dout !== 32'd8) begin bad++; $display("FAIL add_head got=%0d exp=8", if_add.dout); end
        @(posedge clk); #1;
        total++; if (if_add.ack_r !== 1'b1) begin bad++; $display("FAIL add_ack got=%b exp=1", if_add.ack_r); end
        total++; if (if_add.dout !== 32'd8) begin bad++; $display("FAIL add_dout got=%0d exp=8", if_add.dout); end
        total++; if (if_add.count !== 32'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", if_add.count); end
        total++; if (if_add.req_l !== 2'b11) begin bad++; $display("FAIL add_rereq got=%b exp=11", if_add.req_l); end
        @(posedge clk); #1;
        total++; if (if_add.ack_r !== 1'b0) begin bad++; $display("FAIL add_pulse_width got=%b exp=0", if_add.ack_r); end
        total++; if (if_add.occupancy !== 3'd0) begin bad++; $display("FAIL add_occ0 got=%0d exp=0", if_add.occupancy); end
        total++; if (if_add.dout !== 32'd0) begin bad++; $display("FAIL add_empty_dout got=%0h exp=0", if_add.dout); end
    endtask

    task automatic test_sub_muli();
        bit ok;
        do_reset();
        if_sub.req_r = 1'b1;
        if_mul.req_r = 1'b1;
        send(1, 0, 32'd10); send(1, 1, 32'd3); send(1, 2, 32'd2);
        wait_ack(1, 0, ok);
        total++; if (!ok || get_dout(1) !== 32'd5) begin bad++; $display("FAIL sub_10_3_2 got=%0d ack=%0d exp=5", get_dout(1), ok); end
        send(1, 0, 32'd0); send(1, 1, 32'd1); send(1, 2, 32'd0);
        wait_ack(1, 0, ok);
        total++; if (!ok || get_dout(1) !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_wrap got=%0h ack=%0d exp=ffffffff", get_dout(1), ok); end
        send(2, 0, 32'h6000_0000);
        wait_ack(2, 0, ok);
        total++; if (!ok || get_dout(2) !== 32'h2000_0000) begin bad++; $display("FAIL muli_trunc got=%0h ack=%0d exp=20000000", get_dout(2), ok); end
        send(2, 0, 32'd5);
        wait_ack(2, 0, ok);
        total++; if (!ok || get_dout(2) !== 32'd15) begin bad++; $display("FAIL muli_5 got=%0d ack=%0d exp=15", get_dout(2), ok); end
    endtask

    task automatic test_fanout_full();
        bit ok;
        int c0, c1;
        do_reset();
        c0 = ack0_cnt;
        c1 = ack1_cnt;
        if_fan.req_r = 2'b01;
        send(3, 0, 32'd1);
        wait_ack(3, 0, ok);
        total++; if (!ok || if_fan.dout !== 32'd1) begin bad++; $display("FAIL fan_first got=%0d ack=%0d exp=1", if_fan.dout, ok); end
        send(3, 0, 32'd2); send(3, 0, 32'd3); send(3, 0, 32'd4); send(3, 0, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        total++; if (if_fan.occupancy !== 3'd4) begin bad++; $display("FAIL fan_full_occ got=%0d exp=4", if_fan.occupancy); end
        total++; if (if_fan.req_l !== 1'b0) begin bad++; $display("FAIL fan_full_req_l got=%b exp=0", if_fan.req_l); end
        total++; if (if_fan.count !== 32'd4) begin bad++; $display("FAIL fan_full_count got=%0d exp=4", if_fan.count); end
        total++; if (ack0_cnt - c0 !== 1) begin bad++; $display("FAIL fan_no_double_ack got=%0d exp=1", ack0_cnt - c0); end
        total++; if (ack1_cnt - c1 !== 0) begin bad++; $display("FAIL fan_idle_out1 got=%0d exp=0", ack1_cnt - c1); end
        if_fan.req_r = 2'b11;
        @(posedge clk); #1;
        total++; if (if_fan.ack_r !== 2'b10 || if_fan.dout !== 32'd1) begin bad++; $display("FAIL fan_out1_first got=%b/%0d exp=10/1", if_fan.ack_r, if_fan.dout); end
        @(posedge clk); #1;
        total++; if (if_fan.occupancy !== 3'd3 || if_fan.ack_r !== 2'b00) begin bad++; $display("FAIL fan_pop got=%0d/%b exp=3/00", if_fan.occupancy, if_fan.ack_r); end
        @(posedge clk); #1;
        total++; if (if_fan.ack_r !== 2'b11 || if_fan.dout !== 32'd2) begin bad++; $display("FAIL fan_second got=%b/%0d exp=11/2", if_fan.ack_r, if_fan.dout); end
        total++; if (if_fan.occupancy !== 3'd4 || if_fan.count !== 32'd5) begin bad++; $display("FAIL fan_refill got=%0d/%0d exp=4/5", if_fan.occupancy, if_fan.count); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        send(3, 0, 32'd1); send(3, 0, 32'd2); send(3, 0, 32'd3);
        n = 0;
        while (if_fan.req_l !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        // last served bits and the fourth operand land on the same edge
        if_fan.req_r = 2'b11;
        set_lane(3, 0, 32'd4, 1'b1);
        @(posedge clk); #1;
        set_lane(3, 0, 32'd4, 1'b0);
        total++; if (if_fan.ack_r !== 2'b11 || if_fan.dout !== 32'd1 || if_fan.occupancy !== 3'd3) begin
            bad++; $display("FAIL b2b_fire got=%b/%0d/%0d exp=11/1/3", if_fan.ack_r, if_fan.dout, if_fan.occupancy); end
        @(posedge clk); #1;
        total++; if (if_fan.occupancy !== 3'd3 || if_fan.dout !== 32'd2 || if_fan.count !== 32'd4) begin
            bad++; $display("FAIL b2b_push_pop got=%0d/%0d/%0d exp=3/2/4", if_fan.occupancy, if_fan.dout, if_fan.count); end
        fork
            begin
                for (int v = 5; v <= 20; v++) send(3, 0, 32'(v));
            end
            begin
                bit ok;
                for (int k = 2; k <= 20; k++) begin
                    wait_ack(3, 0, ok);
                    total++;
                    if (!ok || if_fan.dout !== 32'(k) || if_fan.ack_r !== 2'b11) begin
                        bad++; $display("FAIL b2b_order got=%0d/%b ack=%0d exp=%0d/11", if_fan.dout, if_fan.ack_r, ok, k);
                    end
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        total++; if (if_fan.occupancy !== 3'd0 || if_fan.count !== 32'd20) begin
            bad++; $display("FAIL b2b_drain got=%0d/%0d exp=0/20", if_fan.occupancy, if_fan.count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        send(0, 0, 32'd1); send(0, 1, 32'd2);
        send(0, 0, 32'd3); send(0, 1, 32'd4);
        send(0, 0, 32'd9);
        total++; if (if_add.occupancy !== 3'd2) begin bad++; $display("FAIL mid_pre_occ got=%0d exp=2", if_add.occupancy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (if_add.occupancy !== 3'd0 || if_add.ack_r !== 1'b0) begin bad++; $display("FAIL mid_occ_ack got=%0d/%b exp=0/0", if_add.occupancy, if_add.ack_r); end
        total++; if (if_add.count !== 32'd0 || if_add.dout !== 32'd0) begin bad++; $display("FAIL mid_count_dout got=%0d/%0h exp=0/0", if_add.count, if_add.dout); end
        total++; if (if_add.req_l !== 2'b00) begin bad++; $display("FAIL mid_req_l got=%b exp=00", if_add.req_l); end
        if_add.req_r = 1'b1;
        send(0, 0, 32'd5); send(0, 1, 32'd6);
        wait_ack(0, 0, ok);
        total++; if (!ok || if_add.dout !== 32'd11 || if_add.count !== 32'd1) begin
            bad++; $display("FAIL mid_restart got=%0d/%0d ack=%0d exp=11/1", if_add.dout, if_add.count, ok); end
    endtask

    task automatic test_stray_ack();
        do_reset();
        send(0, 1, 32'd7);
        set_lane(0, 1, 32'd100, 1'b1);
        @(posedge clk); #1;
        set_lane(0, 1, 32'd100, 1'b0);
        total++; if (if_add.req_l !== 2'b01) begin bad++; $display("FAIL stray_req_l got=%b exp=01", if_add.req_l); end
        send(0, 0, 32'd2);
        @(posedge clk); #1;
        total++; if (if_add.occupancy !== 3'd1 || if_add.dout !== 32'd9) begin
            bad++; $display("FAIL stray_value got=%0d/%0d exp=1/9", if_add.occupancy, if_add.dout); end
    endtask

    initial begin
        rst = 1'b1;
        if_add.din = '0; if_sub.din = '0; if_mul.din = '0; if_fan.din = '0;
        test_reset();
        test_add();
        test_sub_muli();
        test_fanout_full();
        test_back_to_back();
        test_reset_mid();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
